// File: rtl/vga_sync_receiver.sv
// Sink-side VGA timing recovery: rebuilds DrawX/DrawY/blank from hs/vs edges and reports lock/errors.
// Optional frame/error statistics outputs are enabled by defining VGA_RX_STATS_EN.
module vga_sync_receiver #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pixel_en,
    input  logic        hs,
    input  logic        vs,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        locked,
    output logic        frame_start,
    output logic        h_err,
    output logic        v_err
`ifdef VGA_RX_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
`endif
);

    localparam int unsigned CW = 10;
    localparam int unsigned GW = 4;
    localparam logic [CW-1:0] X_SYNC = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] Y_SYNC = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] Y_VIS  = CW'(V_ACTIVE);
    localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        WAIT_V  = 2'd1,
        ACQUIRE = 2'd2,
        TRACK   = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_hs_q;
    logic          r_vs_q;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [GW-1:0] r_good;
    logic          r_hs_bad;
    logic [1:0]    r_miss;

    logic          w_hs_fall;
    logic          w_vs_fall;
    logic          w_x_wrap;
    logic [CW-1:0] w_x_free;
    logic [CW-1:0] w_y_free;
    logic [CW-1:0] w_x_next;
    logic [CW-1:0] w_y_next;
    logic          w_hs_mis;
    logic          w_vs_mis;
    logic          w_hs_miss;
    logic          w_hs_lost;

    // Edge detection and free-running position prediction for the current tick
    assign w_hs_fall = pixel_en & r_hs_q & ~hs;
    assign w_vs_fall = pixel_en & r_vs_q & ~vs;
    assign w_x_wrap  = (r_x == X_LAST);
    assign w_x_free  = w_x_wrap ? '0 : r_x + CW'(1);
    assign w_y_free  = w_x_wrap ? ((r_y == Y_LAST) ? '0 : r_y + CW'(1)) : r_y;
    assign w_x_next  = w_hs_fall ? X_SYNC : w_x_free;
    assign w_y_next  = w_vs_fall ? Y_SYNC : w_y_free;
    assign w_hs_mis  = w_hs_fall & (w_x_free != X_SYNC);
    assign w_vs_mis  = w_vs_fall & (w_y_free != Y_SYNC);
    // A line reached its sync column without any hs fall
    assign w_hs_miss = pixel_en & ~w_hs_fall & (w_x_free == X_SYNC);
    assign w_hs_lost = w_hs_miss & (r_miss == 2'd1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hs_q <= 1'b1;
            r_vs_q <= 1'b1;
            r_x    <= '0;
            r_y    <= '0;
        end else if (pixel_en) begin
            r_hs_q <= hs;
            r_vs_q <= vs;
            r_x    <= w_x_next;
            r_y    <= w_y_next;
        end
    end

    // Lock state machine with registered status and error pulses
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= SEARCH;
            r_good      <= '0;
            r_hs_bad    <= 1'b0;
            r_miss      <= '0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            if (pixel_en) begin
                case (r_state)
                    SEARCH: begin
                        locked <= 1'b0;
                        if (w_hs_fall) r_state <= WAIT_V;
                    end
                    WAIT_V: begin
                        if (w_vs_fall) begin
                            r_state  <= ACQUIRE;
                            r_good   <= '0;
                            r_hs_bad <= 1'b0;
                        end
                    end
                    ACQUIRE: begin
                        if (w_vs_fall) begin
                            r_hs_bad <= 1'b0;
                            if (w_vs_mis || w_hs_mis || r_hs_bad) begin
                                r_good <= '0;
                            end else if ((r_good + GW'(1)) == LOCK_N) begin
                                r_state <= TRACK;
                                r_good  <= '0;
                                r_miss  <= '0;
                                locked  <= 1'b1;
                            end else begin
                                r_good <= r_good + GW'(1);
                            end
                        end else if (w_hs_mis) begin
                            r_good   <= '0;
                            r_hs_bad <= 1'b1;
                        end
                    end
                    TRACK: begin
                        frame_start <= (w_x_next == '0) && (w_y_next == '0);
                        if (w_hs_mis || w_vs_mis || w_hs_lost) begin
                            h_err   <= w_hs_mis | w_hs_lost;
                            v_err   <= w_vs_mis;
                            locked  <= 1'b0;
                            r_state <= SEARCH;
                        end else if (w_hs_fall) begin
                            r_miss <= '0;
                        end else if (w_hs_miss) begin
                            r_miss <= r_miss + 2'(1);
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

    // Recovered raster outputs, one Clk behind the internal counters
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            DrawX <= '0;
            DrawY <= '0;
            blank <= 1'b0;
        end else begin
            DrawX <= r_x;
            DrawY <= r_y;
            blank <= (r_x < X_VIS) && (r_y < Y_VIS);
        end
    end

`ifdef VGA_RX_STATS_EN
    // Frame counter wraps; error counter saturates
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (frame_start) frame_count <= frame_count + 16'(1);
            if ((h_err || v_err) && (err_count != 8'hFF)) err_count <= err_count + 8'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 32x14 raster driven by a reference timing generator.
module tb_vga_sync_receiver;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 4;
    localparam int H_TOTAL  = 32;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 2;
    localparam int V_TOTAL  = 14;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + 4;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + 2;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic       Clk;
    logic       Reset_n;
    logic       pixel_en;
    logic       hs;
    logic       vs;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       locked;
    logic       frame_start;
    logic       h_err;
    logic       v_err;
`ifdef VGA_RX_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  err_count;
`endif

    vga_sync_receiver #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_TOTAL(H_TOTAL),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_TOTAL(V_TOTAL), .LOCK_FRAMES(2)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en), .hs(hs), .vs(vs),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .locked(locked),
        .frame_start(frame_start), .h_err(h_err), .v_err(v_err)
`ifdef VGA_RX_STATS_EN
        , .frame_count(frame_count), .err_count(err_count)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   g_hc, g_vc, g_ticks, t_hc, t_vc;
    int   n_herr, n_verr, n_fs;
    logic s_herr, s_verr, s_fs, s_locked;

    typedef struct {
        logic hs;
        logic vs;
        int   x;
        int   y;
        logic blank;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, g_ticks);
        end
    endtask

    // One pixel tick followed by one idle Clk; pulses captured right after the tick edge
    task automatic apply_tick(input logic h, input logic v);
        pixel_en = 1'b1;
        hs = h;
        vs = v;
        @(posedge Clk); #1;
        pixel_en = 1'b0;
        s_herr = h_err;
        s_verr = v_err;
        s_fs = frame_start;
        s_locked = locked;
        @(posedge Clk); #1;
    endtask

    // Reference generator tick: mode 0 normal, 1 force low, 2 force high, 3 (vs only) one line late
    task automatic gen_step(input int hs_mode, input int vs_mode);
        logic h, v;
        h = !((g_hc >= HS_START) && (g_hc < HS_END));
        v = !((g_vc >= VS_START) && (g_vc < VS_END));
        if (hs_mode == 1) h = 1'b0;
        if (hs_mode == 2) h = 1'b1;
        if (vs_mode == 1) v = 1'b0;
        if (vs_mode == 2) v = 1'b1;
        if (vs_mode == 3) v = !((g_vc >= VS_START + 1) && (g_vc < VS_END + 1));
        t_hc = g_hc;
        t_vc = g_vc;
        apply_tick(h, v);
        g_ticks++;
        if (s_herr) n_herr++;
        if (s_verr) n_verr++;
        if (s_fs) n_fs++;
        if (g_hc == H_TOTAL - 1) begin
            g_hc = 0;
            g_vc = (g_vc == V_TOTAL - 1) ? 0 : g_vc + 1;
        end else begin
            g_hc++;
        end
    endtask

    task automatic advance_to(input int hc, input int vc, input int vs_mode);
        for (int i = 0; i <= FRAME; i++) begin
            if (g_hc == hc && g_vc == vc) break;
            gen_step(0, vs_mode);
        end
    endtask

    task automatic wait_lock(input int budget, output int lock_tick);
        lock_tick = -1;
        for (int i = 0; i < budget; i++) begin
            gen_step(0, 0);
            if (s_locked) begin
                lock_tick = g_ticks - 1;
                break;
            end
        end
    endtask

    task automatic run_chk(input int n);
        for (int i = 0; i < n; i++) begin
            gen_step(0, 0);
            check("drawx", int'(DrawX), t_hc);
            check("drawy", int'(DrawY), t_vc);
            check("blank", int'(blank), int'(t_hc < H_ACTIVE && t_vc < V_ACTIVE));
            check("frame_start", int'(s_fs), int'(t_hc == 0 && t_vc == 0));
            check("locked_run", int'(s_locked), 1);
        end
    endtask

    task automatic reset_all();
        Reset_n = 1'b0;
        pixel_en = 1'b0;
        hs = 1'b1;
        vs = 1'b1;
        g_hc = 0;
        g_vc = 0;
        g_ticks = 0;
        n_herr = 0;
        n_verr = 0;
        n_fs = 0;
        @(posedge Clk); @(posedge Clk); #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lt;
        int herr_at;
        int pulses;
        logic [9:0] dx, dy;
        logic bl;

        vecs[0] = '{1'b1, 1'b1, 1,  0,  1'b1};
        vecs[1] = '{1'b1, 1'b1, 2,  0,  1'b1};
        vecs[2] = '{1'b1, 1'b1, 3,  0,  1'b1};
        vecs[3] = '{1'b0, 1'b1, 20, 0,  1'b0};
        vecs[4] = '{1'b0, 1'b1, 21, 0,  1'b0};
        vecs[5] = '{1'b1, 1'b1, 22, 0,  1'b0};
        vecs[6] = '{1'b0, 1'b1, 20, 0,  1'b0};
        vecs[7] = '{1'b1, 1'b0, 21, 10, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 22, 10, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 23, 10, 1'b0};

        g_ticks = 0;
        Reset_n = 1'b0;
        pixel_en = 1'b0;
        hs = 1'b1;
        vs = 1'b1;
        #2;
        check("rst_drawx", int'(DrawX), 0);
        check("rst_drawy", int'(DrawY), 0);
        check("rst_blank", int'(blank), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_fs", int'(frame_start), 0);
        check("rst_herr", int'(h_err), 0);
        check("rst_verr", int'(v_err), 0);

        // Short directed vectors from reset: free-run, hs loads, vs load
        @(posedge Clk); @(posedge Clk); #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply_tick(vecs[i].hs, vecs[i].vs);
            check($sformatf("vec%0d_x", i), int'(DrawX), vecs[i].x);
            check($sformatf("vec%0d_y", i), int'(DrawY), vecs[i].y);
            check($sformatf("vec%0d_blank", i), int'(blank), int'(vecs[i].blank));
            check($sformatf("vec%0d_herr", i), int'(s_herr), 0);
            check($sformatf("vec%0d_locked", i), int'(s_locked), 0);
        end

        // Clean acquisition: lock on the third vs fall, then three tracked frames
        reset_all();
        wait_lock(4 * FRAME, lt);
        check("clean_lock_tick", lt, 2 * FRAME + VS_START * H_TOTAL);
        n_fs = 0;
        run_chk(3 * FRAME);
        check("clean_fs_count", n_fs, 3);
        check("clean_herr_count", n_herr, 0);
        check("clean_verr_count", n_verr, 0);

        // pixel_en idle: everything frozen while sync inputs wiggle
        dx = DrawX;
        dy = DrawY;
        bl = blank;
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge Clk); #1;
            hs = 1'($urandom);
            vs = 1'($urandom);
            if (h_err || v_err || frame_start) pulses++;
        end
        check("idle_drawx", int'(DrawX), int'(dx));
        check("idle_drawy", int'(DrawY), int'(dy));
        check("idle_blank", int'(blank), int'(bl));
        check("idle_locked", int'(locked), 1);
        check("idle_pulses", pulses, 0);
        run_chk(FRAME);

        // hs falls 4 ticks early while tracking
        advance_to(16, 2, 0);
        n_herr = 0;
        n_verr = 0;
        gen_step(1, 0);
        check("early_hs_herr", int'(s_herr), 1);
        check("early_hs_locked", int'(s_locked), 0);
        check("early_hs_drawx", int'(DrawX), HS_START);
        for (int i = 0; i < 3; i++) gen_step(1, 0);
        wait_lock(5 * FRAME, lt);
        check("early_hs_relock", int'(s_locked), 1);
        check("early_hs_herr_count", n_herr, 1);
        check("early_hs_verr_count", n_verr, 0);
        run_chk(FRAME);

        // vs one line late while tracking
        advance_to(0, 0, 0);
        advance_to(0, 11, 3);
        n_herr = 0;
        n_verr = 0;
        gen_step(0, 3);
        check("late_vs_verr", int'(s_verr), 1);
        check("late_vs_herr", int'(s_herr), 0);
        check("late_vs_locked", int'(s_locked), 0);
        check("late_vs_drawy", int'(DrawY), VS_START);
        advance_to(0, 0, 3);
        wait_lock(5 * FRAME, lt);
        check("late_vs_relock", int'(s_locked), 1);
        check("late_vs_verr_count", n_verr, 1);
        check("late_vs_herr_count", n_herr, 0);
        run_chk(FRAME);

        // hs stuck high: error after the second missed sync column
        advance_to(0, 2, 0);
        n_herr = 0;
        n_verr = 0;
        herr_at = -1;
        for (int i = 0; i < 70; i++) begin
            gen_step(2, 0);
            if (s_herr && herr_at < 0) herr_at = i;
        end
        check("miss_hs_err_tick", herr_at, H_TOTAL + HS_START);
        check("miss_hs_herr_count", n_herr, 1);
        check("miss_hs_locked", int'(s_locked), 0);
        wait_lock(5 * FRAME, lt);
        check("miss_hs_relock", int'(s_locked), 1);
        run_chk(FRAME);

        // Asynchronous reset in the middle of a line
        advance_to(8, 3, 0);
        check("pre_rst_drawx", int'(DrawX), 7);
        #3;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_drawx", int'(DrawX), 0);
        check("mid_rst_drawy", int'(DrawY), 0);
        check("mid_rst_blank", int'(blank), 0);
        check("mid_rst_locked", int'(locked), 0);
        @(posedge Clk); @(posedge Clk); #1;
        Reset_n = 1'b1;
        n_herr = 0;
        for (int i = 0; i < 200; i++) gen_step(0, 0);
        check("post_rst_locked", int'(s_locked), 0);
        check("post_rst_herr_count", n_herr, 0);
        wait_lock(5 * FRAME, lt);
        check("post_rst_relock", int'(s_locked), 1);

        // Late vs during acquisition: silent, and the good-frame count restarts
        reset_all();
        advance_to(0, 1, 0);
        advance_to(0, 0, 0);
        advance_to(0, 1, 3);
        advance_to(0, 0, 3);
        check("acq_fault_herr_count", n_herr, 0);
        check("acq_fault_verr_count", n_verr, 0);
        check("acq_fault_locked", int'(locked), 0);
        wait_lock(6 * FRAME, lt);
        check("acq_fault_lock_tick", lt, 4 * FRAME + VS_START * H_TOTAL);
        check("acq_fault_err_total", n_herr + n_verr, 0);

`ifdef VGA_RX_STATS_EN
        reset_all();
        wait_lock(4 * FRAME, lt);
        for (int i = 0; i < 3 * FRAME; i++) gen_step(0, 0);
        check("stats_frame_count", int'(frame_count), 3);
        check("stats_err_count", int'(err_count), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
